// File: rtl/my_sum.sv
// Registered WIDTH-bit carry-lookahead adder: 3-bit lookahead groups, group-level carry between them.
// Optional signed-overflow output enabled by defining MY_SUM_OVF_EN.
module my_sum #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic             Ci,
  output logic [WIDTH-1:0] Sum,
  output logic             Co
`ifdef MY_SUM_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned GRP  = 3;
  localparam int unsigned NGRP = (WIDTH + GRP - 1) / GRP;

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] carry;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP:0]    grp_c;
  logic             pre_g;
  logic             pre_p;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             co_d, co_q;

  assign gen  = Ain & Bin;
  assign prop = Ain ^ Bin;

  // Per group: carry into each bit from the group's prefix g/p and its carry-in,
  // then group g/p feed the second-level carry into the next group.
  always_comb begin
    carry    = '0;
    grp_g    = '0;
    grp_p    = '0;
    grp_c    = '0;
    pre_g    = 1'b0;
    pre_p    = 1'b1;
    grp_c[0] = Ci;
    for (int unsigned k = 0; k < NGRP; k++) begin
      pre_g = 1'b0;
      pre_p = 1'b1;
      for (int unsigned j = 0; j < GRP; j++) begin
        if (k * GRP + j < WIDTH) begin
          carry[k*GRP+j] = pre_g | (pre_p & grp_c[k]);
          pre_g          = gen[k*GRP+j] | (prop[k*GRP+j] & pre_g);
          pre_p          = pre_p & prop[k*GRP+j];
        end
      end
      grp_g[k]   = pre_g;
      grp_p[k]   = pre_p;
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
  end

  always_comb begin
    sum_d = prop ^ carry;
    co_d  = grp_c[NGRP];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      co_q  <= co_d;
    end
  end

  assign Sum = sum_q;
  assign Co  = co_q;

`ifdef MY_SUM_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  always_comb begin
    ovf_d = carry[WIDTH-1] ^ grp_c[NGRP];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_my_sum.sv
// Self-checking bench for my_sum: directed table, reset sequences, random vectors vs. arithmetic model.
module tb_my_sum;

  localparam int unsigned W = 6;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] Ain;
  logic [W-1:0] Bin;
  logic         Ci;
  logic [W-1:0] Sum;
  logic         Co;
`ifdef MY_SUM_OVF_EN
  logic         ovf;
`endif

  int vecs;
  int errs;

  my_sum #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .Ain  (Ain),
    .Bin  (Bin),
    .Ci   (Ci),
    .Sum  (Sum),
    .Co   (Co)
`ifdef MY_SUM_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition, split into carry-out and low bits.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int unsigned r;
    r = int'(a) + int'(b) + int'(ci);
    return (W+1)'(r);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int sa, sb, r;
    sa = a[W-1] ? int'(a) - 64 : int'(a);
    sb = b[W-1] ? int'(b) - 64 : int'(b);
    r  = sa + sb + int'(ci);
    return (r > 31) || (r < -32);
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    Ain = a;
    Bin = b;
    Ci  = ci;
  endtask

  task automatic check_model(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] r;
    r = ref_sum(a, b, ci);
    check({name, "_sum"}, 8'(Sum), 8'(r[W-1:0]));
    check({name, "_co"}, 8'(Co), 8'(r[W]));
`ifdef MY_SUM_OVF_EN
    check({name, "_ovf"}, 8'(ovf), 8'(ref_ovf(a, b, ci)));
`endif
  endtask

  task automatic check_zero(input string name);
    check({name, "_sum"}, 8'(Sum), 8'd0);
    check({name, "_co"}, 8'(Co), 8'd0);
`ifdef MY_SUM_OVF_EN
    check({name, "_ovf"}, 8'(ovf), 8'd0);
`endif
  endtask

  vec_t tbl[$];

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;

    vecs  = 0;
    errs  = 0;
    rst_n = 1'b0;
    drive(6'd63, 6'd63, 1'b1);

    // Outputs stay zero while reset is held even with clock running.
    #1;
    check_zero("rst_init");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    rst_n = 1'b1;
    #2;
    check_zero("rst_release_pre_edge");
    @(posedge clk);
    #1;
    check("rst_first_sum", 8'(Sum), 8'd63);
    check("rst_first_co", 8'(Co), 8'd1);

    tbl = '{
      '{6'd1,  6'd2,  1'b0, 6'd3,  1'b0},
      '{6'd5,  6'd2,  1'b0, 6'd7,  1'b0},
      '{6'd15, 6'd10, 1'b0, 6'd25, 1'b0},
      '{6'd20, 6'd10, 1'b0, 6'd30, 1'b0},
      '{6'd31, 6'd32, 1'b1, 6'd0,  1'b1},
      '{6'd45, 6'd32, 1'b1, 6'd14, 1'b1},
      '{6'd55, 6'd1,  1'b1, 6'd57, 1'b0},
      '{6'd63, 6'd1,  1'b1, 6'd1,  1'b1},
      '{6'd63, 6'd0,  1'b1, 6'd0,  1'b1},
      '{6'd63, 6'd63, 1'b1, 6'd63, 1'b1},
      '{6'd0,  6'd0,  1'b0, 6'd0,  1'b0},
      '{6'd40, 6'd23, 1'b1, 6'd0,  1'b1},
      '{6'd42, 6'd21, 1'b1, 6'd0,  1'b1},
      '{6'd32, 6'd32, 1'b0, 6'd0,  1'b1},
      '{6'd31, 6'd1,  1'b0, 6'd32, 1'b0}
    };
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].ci);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_sum", i), 8'(Sum), 8'(tbl[i].s));
      check($sformatf("tbl%0d_co", i), 8'(Co), 8'(tbl[i].co));
    end

`ifdef MY_SUM_OVF_EN
    drive(6'd31, 6'd1, 1'b0);
    @(posedge clk); #1;
    check("ovf_31_1", 8'(ovf), 8'd1);
    drive(6'd32, 6'd32, 1'b0);
    @(posedge clk); #1;
    check("ovf_32_32", 8'(ovf), 8'd1);
    check("ovf_32_32_sum", 8'(Sum), 8'd0);
    check("ovf_32_32_co", 8'(Co), 8'd1);
    drive(6'd31, 6'd32, 1'b1);
    @(posedge clk); #1;
    check("ovf_31_32_1", 8'(ovf), 8'd0);
`endif

    // Mid-stream reset: outputs clear at once and the pending result is dropped.
    drive(6'd50, 6'd9, 1'b0);
    @(posedge clk); #1;
    check_model("pre_midrst", 6'd50, 6'd9, 1'b0);
    drive(6'd11, 6'd22, 1'b1);
    #2;
    rst_n = 1'b0;
    #0;
    #1;
    check_zero("midrst_async");
    @(posedge clk); #1;
    check_zero("midrst_held");
    rst_n = 1'b1;
    #1;
    check_zero("midrst_discard");
    drive(6'd7, 6'd8, 1'b0);
    @(posedge clk); #1;
    check_model("post_midrst", 6'd7, 6'd8, 1'b0);

    // Random vectors, with occasional asynchronous reset pulses mid-cycle.
    for (int n = 0; n < 10000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      drive(ra, rb, rc);
      @(posedge clk);
      #1;
      check_model("rand", ra, rb, rc);
      if ($urandom_range(0, 199) == 0) begin
        #($urandom_range(1, 2));
        rst_n = 1'b0;
        #1;
        check_zero("rand_async_rst");
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/my_sum.md
MY_SUM -- requirements
Module: my_sum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the operand and sum width; all values below are for WIDTH=6.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port Ain, input, WIDTH bits: operand A, unsigned.
REQ-006 Port Bin, input, WIDTH bits: operand B, unsigned.
REQ-007 Port Ci, input, 1 bit: carry-in.
REQ-008 Port Sum, output, WIDTH bits: registered sum bits.
REQ-009 Port Co, output, 1 bit: registered carry-out.
REQ-010 Port order after clk and rst_n SHALL be Ain, Bin, Ci, Sum, Co, so the block drops in positionally for ref_sum with clk and rst_n prepended.

Function
REQ-011 {Co,Sum} SHALL equal the full (WIDTH+1)-bit result of Ain + Bin + Ci, with no truncation other than the split into Sum and Co.
REQ-012 The adder SHALL be structural carry-lookahead: per-bit generate = Ain&Bin and propagate = Ain^Bin.
REQ-013 The carry-lookahead SHALL use 3-bit lookahead groups with group generate/propagate and a second-level carry between groups.
REQ-014 Each Sum bit SHALL equal propagate XOR the carry into that bit; no behavioural "+" operator in the datapath.
REQ-015 Inputs SHALL be sampled on the rising clk edge; Sum and Co SHALL be registered and valid one cycle after the inputs are sampled (latency 1, throughput 1 per cycle).
REQ-016 There is no handshake; every rising edge with rst_n high SHALL load a new result.
REQ-017 Wrap-around: a result ≥ 2^WIDTH SHALL set Co=1 and Sum = result mod 2^WIDTH.
REQ-018 The maximum input 63+63+1 SHALL give Sum=63, Co=1.
REQ-019 The minimum input 0+0+0 SHALL give Sum=0, Co=0.
REQ-020 Ci=1 with Ain+Bin = 2^WIDTH−1 SHALL produce full carry ripple through all groups: Sum=0, Co=1.
REQ-021 X or Z on an input SHALL not be masked; no special handling is required.

Reset
REQ-022 Asserting rst_n low SHALL immediately, regardless of clk, force Sum=0 and Co=0, plus ovf=0 when configured.
REQ-023 Outputs SHALL stay zero while rst_n is low.
REQ-024 The first result SHALL load on the first rising clk edge after rst_n returns high.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight result.

Configuration
REQ-026 Macro MY_SUM_OVF_EN: when defined, the block SHALL add output port ovf (1 bit, last in the port list).
REQ-027 ovf SHALL be registered with the same latency as Sum and SHALL indicate two's-complement signed overflow: carry into MSB XOR carry out of MSB.
REQ-028 When MY_SUM_OVF_EN is undefined, ovf and its logic SHALL be absent and the port list SHALL be exactly as in REQ-003 to REQ-010.

Verification
REQ-029 Hold rst_n low, drive Ain=63, Bin=63, Ci=1, toggle clk -> Sum=0, Co=0 throughout; release rst_n -> Sum=63, Co=1 after the next rising edge.
REQ-030 Sequence (Ain,Bin,Ci) = (1,2,0), (5,2,0), (15,10,0), (20,10,0), one per cycle -> Sum = 3, 7, 25, 30 with Co=0, each one cycle after its input.
REQ-031 Sequence (31,32,1), (45,32,1), (55,1,1), (63,1,1) -> {Co,Sum} = {1,0}, {1,14}, {0,57}, {1,1}.
REQ-032 Drive (63,0,1) -> Sum=0, Co=1, proving a full carry chain across both lookahead groups.
REQ-033 With MY_SUM_OVF_EN defined: (31,1,0) -> ovf=1; (32,32,0) -> ovf=1, Sum=0, Co=1; (31,32,1) -> ovf=0.
REQ-034 Random test: 10,000 random vectors compared against a behavioural ref_sum delayed by one cycle -> zero mismatches.
REQ-035 Random test: assert rst_n asynchronously mid-clock-cycle -> outputs go to zero within the same timestep.
